// File: rtl/audio_sample_dac_if.sv
// audio_sample_dac_if: producer-to-DAC sample handshake.
// Ports: wreq (write request), sample ({left, right}), ready (FIFO not full).
// The producer drives the master side; audio_sample_dac is the slave.
interface audio_sample_dac_if #(
    parameter int AUDIO_BITS = 12
);

    logic                    wreq;
    logic [2*AUDIO_BITS-1:0] sample;
    logic                    ready;

    modport master (
        output wreq,
        output sample,
        input  ready
    );

    modport slave (
        input  wreq,
        input  sample,
        output ready
    );

endinterface

// File: rtl/audio_sample_dac.sv
// audio_sample_dac: stereo sample FIFO, frame-rate pop, 1-bit delta-sigma out.
// Ports: clk, aclr (async active-high), bus (wreq/sample/ready, slave),
//   left_out/right_out (DS bits), sample_tick, underrun, overflow (pulses),
//   fill (FIFO occupancy).
module audio_sample_dac #(
    parameter int AUDIO_BITS = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int RATE_DIV   = 512
) (
    input  logic                             clk,
    input  logic                             aclr,
    audio_sample_dac_if.slave                bus,
    output logic                             left_out,
    output logic                             right_out,
    output logic                             sample_tick,
    output logic                             underrun,
    output logic                             overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fill
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(RATE_DIV);
    localparam int SW = 2 * AUDIO_BITS;

    localparam logic [FW-1:0] FULL = FW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(RATE_DIV - 1);

    logic [SW-1:0]         mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         rate_cnt;
    logic [AUDIO_BITS-1:0] cur_left;
    logic [AUDIO_BITS-1:0] cur_right;
    logic [AUDIO_BITS:0]   acc_left;
    logic [AUDIO_BITS:0]   acc_right;

    logic frame;
    logic empty;
    logic do_write;
    logic do_pop;

    // ready looks only at registered occupancy, so a pop in the same
    // cycle never opens a slot for a write against a full FIFO.
    assign bus.ready = (fill != FULL);
    assign empty     = (fill == '0);
    assign frame     = (rate_cnt == LAST);
    assign do_write  = bus.wreq & bus.ready;
    assign do_pop    = frame & ~empty;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            rate_cnt <= '0;
        end else if (frame) begin
            rate_cnt <= '0;
        end else begin
            rate_cnt <= rate_cnt + CW'(1);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= bus.sample;
        end
    end

    // Pointers are exactly log2(depth) bits and wrap on their own.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_write && !do_pop) begin
                fill <= fill + FW'(1);
            end else if (do_pop && !do_write) begin
                fill <= fill - FW'(1);
            end
        end
    end

    // On an empty frame the current sample is held, not zeroed.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            cur_left  <= '0;
            cur_right <= '0;
        end else if (do_pop) begin
            {cur_left, cur_right} <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            sample_tick <= frame;
            underrun    <= frame & empty;
            overflow    <= bus.wreq & ~bus.ready;
        end
    end

    // First-order modulator: the carry out of the low bits is the output
    // bit; dropping it each cycle keeps the residue bounded, so the ones
    // density over 2^AUDIO_BITS cycles equals the sample value exactly.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            acc_left  <= '0;
            acc_right <= '0;
        end else begin
            acc_left  <= {1'b0, acc_left[AUDIO_BITS-1:0]}
                       + {1'b0, cur_left};
            acc_right <= {1'b0, acc_right[AUDIO_BITS-1:0]}
                       + {1'b0, cur_right};
        end
    end

    assign left_out  = acc_left[AUDIO_BITS];
    assign right_out = acc_right[AUDIO_BITS];

endmodule

// File: tb/tb_audio_sample_dac.sv
// tb_audio_sample_dac: table, directed and random checks of audio_sample_dac
// against a queue-based reference model.
module tb_audio_sample_dac;

    localparam int AB    = 12;
    localparam int DEPTH = 4;
    localparam int RD    = 8;
    localparam int N     = 1 << AB;

    logic       clk    = 1'b0;
    logic       clk_en = 1'b0;
    logic       aclr   = 1'b0;
    logic       left_out;
    logic       right_out;
    logic       sample_tick;
    logic       underrun;
    logic       overflow;
    logic [2:0] fill;

    audio_sample_dac_if #(.AUDIO_BITS(AB)) bus ();

    audio_sample_dac #(
        .AUDIO_BITS(AB),
        .FIFO_DEPTH(DEPTH),
        .RATE_DIV  (RD)
    ) dut (
        .clk        (clk),
        .aclr       (aclr),
        .bus        (bus),
        .left_out   (left_out),
        .right_out  (right_out),
        .sample_tick(sample_tick),
        .underrun   (underrun),
        .overflow   (overflow),
        .fill       (fill)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a queue of samples plus the frame/modulator rules.
    int m_q[$];
    int m_cnt;
    int m_cur_l, m_cur_r;
    int m_acc_l, m_acc_r;
    bit m_tick, m_und, m_ovf;

    task automatic model_reset();
        m_q.delete();
        m_cnt   = 0;
        m_cur_l = 0;
        m_cur_r = 0;
        m_acc_l = 0;
        m_acc_r = 0;
        m_tick  = 0;
        m_und   = 0;
        m_ovf   = 0;
    endtask

    task automatic model_step(input bit w, input int s);
        bit frame;
        bit full;
        int h;
        frame   = (m_cnt == RD - 1);
        full    = (m_q.size() == DEPTH);
        m_acc_l = (m_acc_l % N) + m_cur_l;
        m_acc_r = (m_acc_r % N) + m_cur_r;
        m_tick  = frame;
        m_und   = frame && (m_q.size() == 0);
        m_ovf   = w && full;
        if (frame && m_q.size() > 0) begin
            h       = m_q.pop_front();
            m_cur_l = h / N;
            m_cur_r = h % N;
        end
        if (w && !full) m_q.push_back(s);
        m_cnt = (m_cnt + 1) % RD;
    endtask

    task automatic check_all();
        chk("fill", 32'(fill), m_q.size());
        chk("ready", 32'(bus.ready), 32'(m_q.size() != DEPTH));
        chk("sample_tick", 32'(sample_tick), 32'(m_tick));
        chk("underrun", 32'(underrun), 32'(m_und));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("left_out", 32'(left_out), m_acc_l / N);
        chk("right_out", 32'(right_out), m_acc_r / N);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit w, input int s);
        bus.wreq   = w;
        bus.sample = s[23:0];
        @(posedge clk);
        model_step(w, s);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic rst_check(input string name);
        chk({name, "_ready"}, 32'(bus.ready), 1);
        chk({name, "_fill"}, 32'(fill), 0);
        chk({name, "_left"}, 32'(left_out), 0);
        chk({name, "_right"}, 32'(right_out), 0);
        chk({name, "_tick"}, 32'(sample_tick), 0);
        chk({name, "_underrun"}, 32'(underrun), 0);
        chk({name, "_overflow"}, 32'(overflow), 0);
    endtask

    // Asserts reset between edges and checks it acted without a clock edge.
    task automatic do_reset(input string name);
        #2;
        aclr      = 1'b1;
        bus.wreq  = 1'b0;
        #1;
        rst_check(name);
        model_reset();
        @(negedge clk);
        aclr = 1'b0;
    endtask

    typedef struct {
        bit w;
        int s;
        int fill;
        bit rdy;
        bit ovf;
    } vec_t;

    vec_t vt[6];

    initial begin
        int first;
        int ones_l, ones_r;
        int nt, pops;
        int tick_fill[4];
        int tick_edge[4];
        int pct;

        vt[0] = '{1, 1, 1, 1, 0};
        vt[1] = '{1, 2, 2, 1, 0};
        vt[2] = '{1, 3, 3, 1, 0};
        vt[3] = '{1, 4, 4, 0, 0};
        vt[4] = '{1, 5, 4, 0, 1};
        vt[5] = '{0, 0, 4, 0, 0};

        bus.wreq   = 1'b0;
        bus.sample = '0;

        // Power-on reset with the clock stopped.
        #2;
        aclr = 1'b1;
        #1;
        rst_check("por");
        model_reset();
        clk_en = 1'b1;
        @(negedge clk);
        aclr = 1'b0;

        // First tick exactly RD cycles after release.
        first = -1;
        for (int i = 1; i <= 2 * RD; i++) begin
            step(0, 0);
            if (sample_tick && first < 0) first = i;
        end
        chk("first_tick", first, RD);

        // Fill and overflow table.
        do_reset("rst_fill");
        for (int i = 0; i < 6; i++) begin
            step(vt[i].w, vt[i].s);
            chk("tbl_fill", 32'(fill), vt[i].fill);
            chk("tbl_ready", 32'(bus.ready), 32'(vt[i].rdy));
            chk("tbl_overflow", 32'(overflow), 32'(vt[i].ovf));
        end
        // Only four entries were kept: five ticks give four pops.
        pops = 0;
        nt   = 0;
        for (int i = 7; i <= 5 * RD; i++) begin
            step(0, 0);
            if (sample_tick) begin
                nt++;
                if (!underrun) pops++;
            end
        end
        chk("fill_ticks", nt, 5);
        chk("sample5_absent", pops, 4);

        // Order and rate.
        do_reset("rst_order");
        step(1, 24'h001001);
        step(1, 24'h002002);
        step(1, 24'h003003);
        nt = 0;
        for (int i = 4; i <= 4 * RD; i++) begin
            step(0, 0);
            if (sample_tick && nt < 4) begin
                tick_fill[nt] = 32'(fill);
                tick_edge[nt] = i;
                nt++;
            end
        end
        chk("order_ticks", nt, 4);
        for (int k = 0; k < 4; k++) begin
            chk("order_tick_edge", tick_edge[k], RD * (k + 1));
            chk("order_fill", tick_fill[k], (k < 3) ? 2 - k : 0);
        end
        chk("order_underrun", 32'(underrun), 1);

        // Density: left=2048, right=0, then left=4095, right=1.
        for (int d = 0; d < 2; d++) begin
            int lv, rv;
            lv = (d == 0) ? 2048 : 4095;
            rv = (d == 0) ? 0 : 1;
            do_reset("rst_density");
            step(1, lv * N + rv);
            for (int i = 2; i <= RD + 1; i++) step(0, 0);
            ones_l = 0;
            ones_r = 0;
            for (int i = 0; i < N; i++) begin
                step(0, 0);
                ones_l += int'(left_out);
                ones_r += int'(right_out);
            end
            chk("density_left", ones_l, lv);
            chk("density_right", ones_r, rv);
        end

        // Underrun with a write at the same edge.
        do_reset("rst_under");
        for (int i = 1; i < RD; i++) step(0, 0);
        step(1, 24'h0AB0CD);
        chk("und_pulse", 32'(underrun), 1);
        chk("und_fill", 32'(fill), 1);
        step(0, 0);
        chk("und_not_sticky", 32'(underrun), 0);
        for (int i = RD + 2; i < 2 * RD; i++) step(0, 0);
        step(0, 0);
        chk("und_pop_tick", 32'(sample_tick), 1);
        chk("und_pop_fill", 32'(fill), 0);
        chk("und_pop_noflag", 32'(underrun), 0);
        for (int i = 0; i < 3 * RD; i++) step(0, 0);

        // Mid-stream reset with a write in the release cycle.
        do_reset("rst_mid0");
        step(1, 24'h800400);
        step(1, 24'hC00100);
        step(1, 24'h400FFF);
        step(1, 24'h123456);
        for (int i = 5; i <= RD + 5; i++) step(0, 0);
        chk("mid_fill", 32'(fill), 3);
        do_reset("rst_mid");
        step(1, 24'h777333);
        chk("mid_release_write", 32'(fill), 1);
        for (int i = 2; i <= RD; i++) step(0, 0);
        chk("mid_tick", 32'(sample_tick), 1);
        chk("mid_fill_after", 32'(fill), 0);
        for (int i = 1; i <= RD; i++) step(0, 0);
        chk("mid_no_stale", 32'(underrun), 1);

        // Randomized traffic at several write rates.
        do_reset("rst_rand");
        for (int p = 0; p < 4; p++) begin
            pct = (p == 0) ? 5 : (p == 1) ? 15 : (p == 2) ? 60 : 95;
            for (int i = 0; i < 200; i++) begin
                step($urandom_range(0, 99) < pct,
                     int'($urandom & 32'h00FF_FFFF));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_sample_dac.md
# audio_sample_dac

Receiving end of the team's audio sample interface: accepts stereo samples from a producer such as the tone generator through the `wreq`/`sample`/`ready` handshake and buffers them in a small FIFO. It consumes one sample per audio frame from a fixed-ratio clock divider and drives each channel as a 1-bit first-order delta-sigma stream on `left_out`/`right_out`, which feed external RC filters. It sits between the sample producer and the board's audio output pins, on the audio clock domain.

## Interface
- `AUDIO_BITS`, 12: bits per channel, unsigned, 0 = minimum and 2^AUDIO_BITS-1 = full scale.
- `FIFO_DEPTH`, 4: sample FIFO entries; a power of two, at least 2.
- `RATE_DIV`, 512: `clk` cycles per audio frame (22.5792 MHz / 512 = 44.1 kHz); at least 2.
- `clk`  in  1  audio clock; all logic is on the rising edge.
- `aclr`  in  1  asynchronous reset, active-high.
- `wreq`  in  1  producer write request.
- `sample`  in  2*AUDIO_BITS  `[2*AUDIO_BITS-1:AUDIO_BITS]` = left, `[AUDIO_BITS-1:0]` = right.
- `ready`  out  1  FIFO not full; a write is accepted only when high.
- `left_out`  out  1  left delta-sigma bit.
- `right_out`  out  1  right delta-sigma bit.
- `sample_tick`  out  1  one-cycle pulse on every frame boundary.
- `underrun`  out  1  one-cycle pulse when a frame boundary finds the FIFO empty.
- `overflow`  out  1  one-cycle pulse when `wreq` is high while `ready` is low.
- `fill`  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

## Operation
- Reset values (asynchronous, take effect immediately, no clock needed): FIFO empty, `fill`=0, `ready`=1, rate counter=0, current left/right sample=0, both accumulators=0, and `left_out`, `right_out`, `sample_tick`, `underrun`, `overflow` all 0.
- `ready` = (`fill` != FIFO_DEPTH). It is combinational from registered state and never depends on `wreq`.
- Write: on a rising edge with `wreq`=1 and `ready`=1, `sample` is stored at the tail. Holding `wreq` high writes one entry per cycle. The producer does not need to drop `wreq` between writes.
- Write while full: the data is discarded, the FIFO is unchanged, and `overflow` pulses on the next cycle. A pop in the same cycle does not make a full FIFO writable.
- Rate counter runs 0..RATE_DIV-1 and wraps. In the cycle when the counter = RATE_DIV-1:
  - `sample_tick` is registered high for the following cycle.
  - If the FIFO is not empty, the head entry is popped into the current-sample registers.
  - If the FIFO is empty, the current sample is held (no zeroing) and `underrun` pulses.
- Simultaneous write and pop on a non-full FIFO: both occur, `fill` is unchanged, and ordering is preserved (FIFO order, no reordering).
- Delta-sigma, per channel, every cycle: `acc` (AUDIO_BITS+1 bits) <= {1'b0, acc[AUDIO_BITS-1:0]} + cur. The output bit is the registered `acc[AUDIO_BITS]`. Over any 2^AUDIO_BITS consecutive cycles with a constant `cur`, the number of output ones equals `cur` exactly.
- Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. `fill` distinguishes full from empty.

## Timing
- Write-to-`fill` latency: 1 cycle. `ready` drops in the cycle after the write that fills the FIFO.
- Pop to the new `cur`: visible 1 cycle after the RATE_DIV-1 edge. The first output bit reflecting the new value appears 1 cycle after that.
- `sample_tick` period = RATE_DIV cycles exactly. The first tick occurs RATE_DIV cycles after reset release.
- `underrun` and `overflow` are single-cycle pulses and are not sticky. They are asserted in the same cycle as the event's registered effects.
- Reset asserted mid-frame or mid-write: all state clears asynchronously. On release, the first clock edge behaves as rate count 0 with an empty FIFO. Any write presented in the release cycle is accepted normally.

## Test plan
- Reset: assert `aclr` with `clk` stopped -> `ready`=1, `fill`=0, and `left_out`/`right_out`/pulses all 0 immediately; release -> first `sample_tick` exactly 512 cycles later.
- Fill and overflow (FIFO_DEPTH=4): 5 back-to-back `wreq` cycles with samples 1..5 -> `fill` 1,2,3,4; `ready` low after the 4th write; one `overflow` pulse; sample 5 is absent from later pops.
- Order and rate (RATE_DIV=8): preload 0x001001, 0x002002, 0x003003 -> `sample_tick` every 8 cycles; `cur` takes these values in order; `fill` goes 3,2,1,0.
- Density: `cur` left=2048, right=0, AUDIO_BITS=12 -> exactly 2048 ones on `left_out` and 0 on `right_out` in any 4096-cycle window; left=4095 -> exactly 4095 ones.
- Underrun: empty FIFO at a tick -> one `underrun` pulse and `cur` unchanged; a simultaneous write at the tick edge is accepted and popped at the next tick.
- Mid-stream reset: `aclr` pulsed while `fill`=3 and outputs toggling -> everything clears at once; resumes from the empty state with no stale samples.
